// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared pipeline types for the hazard/stall controller
package processor_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_POST_BUBBLE = 2'd1,
    ST_FLUSH       = 2'd2
  } hsc_state_e;

  localparam int REG_W_DEFAULT = 4;

  // addi x0,x0,0 -- the word a squashed ID/EX slot represents
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_src,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_uses_src,
  input  logic             id_uses_dst,
  output logic             hz
);

  assign hz = ex_mem_read &
              ((id_uses_src & (id_src == ex_rd)) | (id_uses_dst & (id_dst == ex_rd)));

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use stall, branch flush and memory freeze control
// Defining HSC_PERF_CNT_EN builds the stall_cnt performance counter.
module hazard_stall_controller
  import processor_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int REG_W        = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_src,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_uses_src,
  input  logic             id_uses_dst,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             after_bubble,
  output logic             mem_timeout,
  output logic [15:0]      stall_cnt
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TO_LIMIT   = 8'(MEM_TIMEOUT);

  hsc_state_e state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  logic       hz;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_src      (id_src),
    .id_dst      (id_dst),
    .id_uses_src (id_uses_src),
    .id_uses_dst (id_uses_dst),
    .hz          (hz)
  );

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    idex_bubble   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    after_bubble  = (state_q == ST_POST_BUBBLE);

    if (mem_busy) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_POST_BUBBLE: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = FLUSH_INIT;
            state_d     = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
          end else if (hz && state_q == ST_RUN) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
            state_d       = ST_POST_BUBBLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          ifid_flush  = 1'b1;
          flush_cnt_d = flush_cnt_q - 2'd1;
          if (flush_cnt_q == 2'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Reset must look like an idle RUN cycle regardless of pending inputs
    if (!rst_n) begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      after_bubble  = 1'b0;
    end
  end

  always_comb begin
    to_cnt_d = 8'd0;
    if (mem_busy) to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
    mem_timeout_d = mem_timeout_q | (mem_busy & (to_cnt_d == TO_LIMIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 2'd0;
      to_cnt_q      <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HSC_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_en && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
